mem_stage: RTL and testbench

- MEM pipeline stage of the 5-stage LoongArch core; the upstream producer of the `mem_to_wb` valid/allowin interface that WB consumes.
- Holds one instruction from EX and waits for the data-SRAM response when EX issued a request.
- Performs load byte/half selection and sign/zero extension, then presents `{rf_we, rf_waddr, rf_wdata, pc}` to WB.
- Drives a forwarding/hazard bus back to ID.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_load_extend.sv | 29 ++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: bus widths, EX->MEM field
// offsets, load-op one-hot bit indices and the per-instruction state type.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_W = 77;
  localparam int unsigned MEM_TO_WB_W = 70;
  localparam int unsigned MEM_TO_ID_W = 39;

  // ex_to_mem_bus = {mem_req, mem_we, ld_op[4:0], rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}
  localparam int unsigned EM_MEM_REQ  = 76;
  localparam int unsigned EM_MEM_WE   = 75;
  localparam int unsigned EM_LD_OP_HI = 74;
  localparam int unsigned EM_LD_OP_LO = 70;
  localparam int unsigned EM_RF_WE    = 69;
  localparam int unsigned EM_WADDR_HI = 68;
  localparam int unsigned EM_WADDR_LO = 64;
  localparam int unsigned EM_ALU_HI   = 63;
  localparam int unsigned EM_ALU_LO   = 32;
  localparam int unsigned EM_PC_HI    = 31;
  localparam int unsigned EM_PC_LO    = 0;

  // ld_op = {ld_b, ld_h, ld_w, ld_bu, ld_hu}
  localparam int unsigned LD_B  = 4;
  localparam int unsigned LD_H  = 3;
  localparam int unsigned LD_W  = 2;
  localparam int unsigned LD_BU = 1;
  localparam int unsigned LD_HU = 0;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_DONE
  } mem_state_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data alignment: picks the addressed byte/half from a 32-bit word and
// sign- or zero-extends it according to the one-hot load op.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    if (ld_op[LD_B])
      result = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU])
      result = {24'h0, byte_sel};
    else if (ld_op[LD_H])
      result = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU])
      result = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for the data-SRAM
// response when needed, extends load data and hands the result to WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned IN_BUS_W  = EX_TO_MEM_W,
  parameter int unsigned OUT_BUS_W = MEM_TO_WB_W
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_allowin,
  input  logic                   ex_to_mem_valid,
  input  logic [IN_BUS_W-1:0]    ex_to_mem_bus,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   wb_allowin,
  output logic                   mem_to_wb_valid,
  output logic [OUT_BUS_W-1:0]   mem_to_wb_bus,
  output logic [MEM_TO_ID_W-1:0] mem_to_id_bus
);

  mem_state_t state, state_nx;

  logic        mem_valid;
  logic        ready_go;
  logic        accept;
  logic        data_ok_in_wait;
  logic        buf_capture;

  logic        lat_mem_req;
  logic [4:0]  lat_ld_op;
  logic        lat_rf_we;
  logic [4:0]  lat_rf_waddr;
  logic [31:0] lat_alu_result;
  logic [31:0] lat_pc;

  logic        resp_buf_valid;
  logic [31:0] resp_buf_data;

  logic        in_mem_req;
  logic        mem_we_unused;
  logic [31:0] ld_rdata;
  logic [31:0] ld_result;
  logic [31:0] rf_wdata;
  logic        ld_wait;

  assign in_mem_req    = ex_to_mem_bus[EM_MEM_REQ];
  // Stores are distinguished upstream; MEM only needs to wait for their data_ok.
  assign mem_we_unused = ex_to_mem_bus[EM_MEM_WE];

  assign mem_valid       = (state != MS_IDLE);
  assign data_ok_in_wait = (state == MS_WAIT) & data_sram_data_ok;
  assign ready_go        = ~lat_mem_req | data_ok_in_wait | resp_buf_valid;
  assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & ready_go;
  assign accept          = ex_to_mem_valid & mem_allowin;

  always_comb begin
    state_nx    = state;
    buf_capture = 1'b0;
    case (state)
      MS_IDLE: begin
        if (ex_to_mem_valid)
          state_nx = in_mem_req ? MS_WAIT : MS_DONE;
      end
      MS_WAIT: begin
        if (data_sram_data_ok) begin
          if (wb_allowin) begin
            if (ex_to_mem_valid)
              state_nx = in_mem_req ? MS_WAIT : MS_DONE;
            else
              state_nx = MS_IDLE;
          end else begin
            // WB is stalled: hold the response so data_ok need not repeat.
            state_nx    = MS_DONE;
            buf_capture = 1'b1;
          end
        end
      end
      MS_DONE: begin
        if (wb_allowin) begin
          if (ex_to_mem_valid)
            state_nx = in_mem_req ? MS_WAIT : MS_DONE;
          else
            state_nx = MS_IDLE;
        end
      end
      default: state_nx = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= MS_IDLE;
      lat_mem_req    <= 1'b0;
      lat_ld_op      <= '0;
      lat_rf_we      <= 1'b0;
      lat_rf_waddr   <= '0;
      lat_alu_result <= '0;
      lat_pc         <= '0;
      resp_buf_valid <= 1'b0;
      resp_buf_data  <= '0;
    end else begin
      state <= state_nx;
      if (mem_allowin)
        resp_buf_valid <= 1'b0;
      else if (buf_capture)
        resp_buf_valid <= 1'b1;
      if (buf_capture)
        resp_buf_data <= data_sram_rdata;
      if (accept) begin
        lat_mem_req    <= in_mem_req;
        lat_ld_op      <= ex_to_mem_bus[EM_LD_OP_HI:EM_LD_OP_LO];
        lat_rf_we      <= ex_to_mem_bus[EM_RF_WE];
        lat_rf_waddr   <= ex_to_mem_bus[EM_WADDR_HI:EM_WADDR_LO];
        lat_alu_result <= ex_to_mem_bus[EM_ALU_HI:EM_ALU_LO];
        lat_pc         <= ex_to_mem_bus[EM_PC_HI:EM_PC_LO];
      end
    end
  end

  assign ld_rdata = resp_buf_valid ? resp_buf_data : data_sram_rdata;

  load_extend u_load_extend (
    .ld_op  (lat_ld_op),
    .addr   (lat_alu_result[1:0]),
    .rdata  (ld_rdata),
    .result (ld_result)
  );

  assign rf_wdata = (|lat_ld_op) ? ld_result : lat_alu_result;
  assign ld_wait  = mem_valid & (|lat_ld_op) & ~ready_go;

  assign mem_to_wb_bus = {lat_rf_we, lat_rf_waddr, rf_wdata, lat_pc};
  assign mem_to_id_bus = {ld_wait, lat_rf_we & mem_valid, lat_rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, delayed/buffered loads,
// back-to-back transfers, stores and reset during an outstanding request.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        mem_allowin;
  logic        ex_to_mem_valid;
  logic [76:0] ex_to_mem_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [38:0] mem_to_id_bus;

  int unsigned n_tests;
  int unsigned n_fail;
  logic        outstanding;

  mem_stage #(.IN_BUS_W(77), .OUT_BUS_W(70)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_allowin       (mem_allowin),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [76:0] mk(input logic req, input logic we, input logic [4:0] ldop,
                                     input logic rfwe, input logic [4:0] waddr,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {req, we, ldop, rfwe, waddr, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A response must only ever answer a request MEM has accepted.
  always @(posedge clk) begin
    if (!reset && data_sram_data_ok)
      check("data_ok_ordering", outstanding, 1'b1);
    if (reset)
      outstanding <= 1'b0;
    else if (ex_to_mem_valid && mem_allowin && ex_to_mem_bus[76])
      outstanding <= 1'b1;
    else if (data_sram_data_ok)
      outstanding <= 1'b0;
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    wb_allowin = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", mem_to_wb_valid, 1'b0);
    check("rst_wb_bus", mem_to_wb_bus, 70'h0);
    check("rst_id_bus", mem_to_id_bus, 39'h0);
    check("rst_allowin", mem_allowin, 1'b1);
    reset = 1'b0;

    // ALU op passes straight through
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b0, 1'b0, 5'b00000, 1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000);
    tick();
    ex_to_mem_valid = 1'b0;
    check("alu_valid", mem_to_wb_valid, 1'b1);
    check("alu_bus", mem_to_wb_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000});
    check("alu_allowin", mem_allowin, 1'b1);
    check("alu_id_bus", mem_to_id_bus, {1'b0, 1'b1, 5'd5, 32'h0000_1234});
    tick();
    check("alu_drain", mem_to_wb_valid, 1'b0);

    // ld_b from byte 3, response after 3 waiting cycles
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b0, 5'b10000, 1'b1, 5'd6, 32'h0000_1003, 32'h1c00_0004);
    tick();
    ex_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ldb_wait", mem_to_id_bus[38], 1'b1);
      check("ldb_hold_valid", mem_to_wb_valid, 1'b0);
      check("ldb_hold_allowin", mem_allowin, 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF_0000;
    #1;
    check("ldb_valid", mem_to_wb_valid, 1'b1);
    check("ldb_bus", mem_to_wb_bus, {1'b1, 5'd6, 32'hFFFF_FF80, 32'h1c00_0004});
    check("ldb_wait_clr", mem_to_id_bus[38], 1'b0);
    check("ldb_allowin", mem_allowin, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
    check("ldb_drain", mem_to_wb_valid, 1'b0);

    // ld_hu upper half, response while WB stalls for 2 cycles
    wb_allowin = 1'b0;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b0, 5'b00001, 1'b1, 5'd7, 32'h0000_2002, 32'h1c00_0008);
    tick();
    ex_to_mem_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8001_7FFF;
    #1;
    check("ldhu_valid", mem_to_wb_valid, 1'b1);
    check("ldhu_wdata", mem_to_wb_bus[63:32], 32'h0000_8001);
    check("ldhu_allowin", mem_allowin, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0000_0000;
    #1;
    check("ldhu_buf_valid", mem_to_wb_valid, 1'b1);
    check("ldhu_buf_wdata", mem_to_wb_bus[63:32], 32'h0000_8001);
    check("ldhu_buf_allowin", mem_allowin, 1'b0);
    tick();
    wb_allowin = 1'b1;
    #1;
    check("ldhu_release_allowin", mem_allowin, 1'b1);
    check("ldhu_release_bus", mem_to_wb_bus, {1'b1, 5'd7, 32'h0000_8001, 32'h1c00_0008});
    check("ldhu_release_valid", mem_to_wb_valid, 1'b1);
    tick();
    check("ldhu_drain", mem_to_wb_valid, 1'b0);

    // Back-to-back ld_w then ALU with immediate response
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b0, 5'b00100, 1'b1, 5'd8, 32'h0000_3000, 32'h1c00_000c);
    tick();
    ex_to_mem_bus = mk(1'b0, 1'b0, 5'b00000, 1'b1, 5'd9, 32'h0000_0007, 32'h1c00_0010);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    check("b2b_ldw_valid", mem_to_wb_valid, 1'b1);
    check("b2b_ldw_bus", mem_to_wb_bus, {1'b1, 5'd8, 32'hDEAD_BEEF, 32'h1c00_000c});
    check("b2b_allowin", mem_allowin, 1'b1);
    tick();
    ex_to_mem_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    check("b2b_alu_valid", mem_to_wb_valid, 1'b1);
    check("b2b_alu_bus", mem_to_wb_bus, {1'b1, 5'd9, 32'h0000_0007, 32'h1c00_0010});
    tick();
    check("b2b_drain", mem_to_wb_valid, 1'b0);

    // Store: waits 2 cycles for data_ok, never raises ld_wait
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b1, 5'b00000, 1'b0, 5'd0, 32'h0000_4000, 32'h1c00_0014);
    tick();
    ex_to_mem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("st_hold_valid", mem_to_wb_valid, 1'b0);
      check("st_hold_ldwait", mem_to_id_bus[38], 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5555_AAAA;
    #1;
    check("st_valid", mem_to_wb_valid, 1'b1);
    check("st_bus", mem_to_wb_bus, {1'b0, 5'd0, 32'h0000_4000, 32'h1c00_0014});
    check("st_ldwait", mem_to_id_bus[38], 1'b0);
    tick();
    data_sram_data_ok = 1'b0;

    // Buffered response, then a new load enters as the old one leaves
    wb_allowin = 1'b0;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b0, 5'b00100, 1'b1, 5'd11, 32'h0000_6000, 32'h1c00_0020);
    tick();
    ex_to_mem_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1122_3344;
    tick();
    data_sram_data_ok = 1'b0;
    wb_allowin = 1'b1;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b0, 5'b01000, 1'b1, 5'd12, 32'h0000_6002, 32'h1c00_0024);
    #1;
    check("swap_old_bus", mem_to_wb_bus, {1'b1, 5'd11, 32'h1122_3344, 32'h1c00_0020});
    check("swap_allowin", mem_allowin, 1'b1);
    tick();
    ex_to_mem_valid = 1'b0;
    check("swap_new_waits", mem_to_wb_valid, 1'b0);
    check("swap_new_ldwait", mem_to_id_bus[38], 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8000_1234;
    #1;
    check("swap_ldh_bus", mem_to_wb_bus, {1'b1, 5'd12, 32'hFFFF_8000, 32'h1c00_0024});
    tick();
    data_sram_data_ok = 1'b0;
    check("swap_drain", mem_to_wb_valid, 1'b0);

    // Reset while waiting for a response
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b1, 1'b0, 5'b00100, 1'b1, 5'd10, 32'h0000_5000, 32'h1c00_0018);
    tick();
    ex_to_mem_valid = 1'b0;
    check("rstw_ldwait", mem_to_id_bus[38], 1'b1);
    reset = 1'b1;
    tick();
    check("rstw_valid", mem_to_wb_valid, 1'b0);
    check("rstw_wb_bus", mem_to_wb_bus, 70'h0);
    check("rstw_id_bus", mem_to_id_bus, 39'h0);
    check("rstw_allowin", mem_allowin, 1'b1);
    reset = 1'b0;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(1'b0, 1'b0, 5'b00000, 1'b1, 5'd3, 32'h0000_00AB, 32'h1c00_001c);
    tick();
    ex_to_mem_valid = 1'b0;
    check("rstw_after_bus", mem_to_wb_bus, {1'b1, 5'd3, 32'h0000_00AB, 32'h1c00_001c});
    check("rstw_after_valid", mem_to_wb_valid, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
